weight_ram_loader: RTL and testbench

Write-side companion to the weight-RAM read address generator in the convolutional layer. It accepts a stream of kernel weights over a valid/ready handshake and packs each kernel row of `kernel_size` weights into one RAM word. It writes rows to weight-RAM addresses 0..kernel_size-1, which is the same address range the read side cycles through on `pop_w`. It signals completion so the controller can start issuing `pop_w`.

---
 rtl/weight_ram_loader_if.sv | 25 ++
 rtl/weight_ram_loader.sv | 71 +++++++
 tb/tb_weight_ram_loader.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/weight_ram_loader_if.sv
// weight_ram_loader_if: weight-beat handshake plus weight-RAM write port of the loader.
interface weight_ram_loader_if #(
  parameter int DATA_W = 8,
  parameter int K_MAX  = 7
);
  logic                    start;
  logic [2:0]              kernel_size;
  logic                    w_valid;
  logic [DATA_W-1:0]       w_data;
  logic                    w_ready;
  logic                    wr_RAM_weight;
  logic [2:0]              addr_RAM_weight_wr;
  logic [K_MAX*DATA_W-1:0] din_RAM_weight;
  logic                    load_done;
  logic                    busy;
  logic                    cfg_err;
  modport master (
    output start, kernel_size, w_valid, w_data,
    input  w_ready, wr_RAM_weight, addr_RAM_weight_wr, din_RAM_weight, load_done, busy, cfg_err
  );
  modport slave (
    input  start, kernel_size, w_valid, w_data,
    output w_ready, wr_RAM_weight, addr_RAM_weight_wr, din_RAM_weight, load_done, busy, cfg_err
  );
endinterface

// File: rtl/weight_ram_loader.sv
// weight_ram_loader: packs streamed kernel weights into one RAM word per row, rows to addresses 0..k-1.
module weight_ram_loader #(
  parameter int DATA_W = 8,
  parameter int K_MAX  = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  weight_ram_loader_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
  state_t                  state_q, state_d;
  logic [2:0]              k_q, k_d, col_q, col_d, row_q, row_d;
  logic [K_MAX*DATA_W-1:0] pack_q, pack_d;
  logic                    cfg_err_q, cfg_err_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pack_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pack_q    <= pack_d;
      cfg_err_q <= cfg_err_d;
    end
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    col_d     = col_q;
    row_d     = row_q;
    pack_d    = pack_q;
    cfg_err_d = 1'b0;
    case (state_q)
      IDLE:
        if (bus.start) begin
          if (bus.kernel_size != 3'd0) begin
            k_d     = bus.kernel_size;
            col_d   = '0;
            row_d   = '0;
            pack_d  = '0;
            state_d = LOAD;
          end else cfg_err_d = 1'b1;
        end
      LOAD:
        if (bus.w_valid) begin
          pack_d[int'(col_q)*DATA_W +: DATA_W] = bus.w_data;
          col_d   = (col_q == k_q - 3'd1) ? 3'd0 : col_q + 3'd1;
          state_d = (col_q == k_q - 3'd1) ? WRITE : LOAD;
        end
      WRITE: begin
        pack_d  = '0;
        row_d   = (row_q == k_q - 3'd1) ? row_q : row_q + 3'd1;
        state_d = (row_q == k_q - 3'd1) ? DONE : LOAD;
      end
      default: state_d = IDLE;
    endcase
  end
  // Address and data are gated to zero outside WRITE so the RAM port is quiet between rows.
  assign bus.w_ready            = state_q == LOAD;
  assign bus.wr_RAM_weight      = state_q == WRITE;
  assign bus.addr_RAM_weight_wr = state_q == WRITE ? row_q : 3'd0;
  assign bus.din_RAM_weight     = state_q == WRITE ? pack_q : '0;
  assign bus.load_done          = state_q == DONE;
  assign bus.busy               = state_q != IDLE;
  assign bus.cfg_err            = cfg_err_q;
endmodule

// File: tb/tb_weight_ram_loader.sv
// tb_weight_ram_loader: directed checks of the weight RAM loader with hand-computed expectations.
module tb_weight_ram_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  int cyc, idx, done_cyc, err_cyc, err_n, busy_hi, rdy_bad, ign_cyc = -1;
  logic [2:0]  wa[$];
  logic [55:0] wd[$];
  int          wc[$];
  logic [7:0]  beats[$];
  logic [55:0] exp_w;
  weight_ram_loader_if #(.DATA_W(8), .K_MAX(7)) bus();
  weight_ram_loader #(.DATA_W(8), .K_MAX(7)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.wr_RAM_weight) begin
      wa.push_back(bus.addr_RAM_weight_wr);
      wd.push_back(bus.din_RAM_weight);
      wc.push_back(cyc);
    end
    if (bus.load_done) done_cyc = cyc;
    if (bus.cfg_err) begin err_cyc = cyc; err_n++; end
    if (bus.busy) busy_hi++;
    if (bus.w_ready !== (bus.busy && !bus.wr_RAM_weight && !bus.load_done)) rdy_bad++;
  endtask
  task automatic clear();
    wa.delete(); wd.delete(); wc.delete();
    done_cyc = -1; err_cyc = -1; err_n = 0; busy_hi = 0; rdy_bad = 0; cyc = 0; idx = 0;
  endtask
  task automatic run(input logic [2:0] k, input bit bub, input int limit);
    logic acc;
    clear();
    bus.start = 1'b1; bus.kernel_size = k;
    tick();
    bus.start = 1'b0;
    while (done_cyc < 0 && err_cyc < 0 && cyc < limit) begin
      bus.start = (cyc == ign_cyc);
      if (bus.start) bus.kernel_size = 3'd1;
      bus.w_valid = (idx < beats.size()) && !(bub && cyc % 2 == 0);
      bus.w_data = idx < beats.size() ? beats[idx] : 8'h00;
      acc = bus.w_valid && bus.w_ready;
      tick();
      if (acc) idx++;
    end
    bus.w_valid = 1'b0; bus.start = 1'b0;
    tick();
  endtask
  initial begin
    bus.start = 1'b0; bus.kernel_size = '0; bus.w_valid = 1'b0; bus.w_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {bus.w_ready, bus.wr_RAM_weight, bus.addr_RAM_weight_wr, bus.din_RAM_weight,
        bus.load_done, bus.busy, bus.cfg_err}, 64'd0);
    rst_n = 1'b1;
    tick();
    // k=3 contiguous
    beats.delete();
    for (int i = 1; i <= 9; i++) beats.push_back(8'(i));
    run(3'd3, 1'b0, 40);
    chk("k3_nwr", wa.size(), 3);
    if (wa.size() == 3) begin
      chk("k3_row0", {wa[0], wd[0], 5'(wc[0])}, {3'd0, 56'h030201, 5'd4});
      chk("k3_row1", {wa[1], wd[1], 5'(wc[1])}, {3'd1, 56'h060504, 5'd8});
      chk("k3_row2", {wa[2], wd[2], 5'(wc[2])}, {3'd2, 56'h090807, 5'd12});
    end
    chk("k3_done_cyc", done_cyc, 13);
    chk("k3_busy14", {bus.busy, 8'(cyc)}, {1'b0, 8'd14});
    chk("k3_busy_cycles", busy_hi, 13);
    chk("k3_ready", rdy_bad, 0);
    // k=1
    beats.delete(); beats.push_back(8'hAA);
    run(3'd1, 1'b0, 20);
    chk("k1_nwr", wa.size(), 1);
    if (wa.size() == 1) chk("k1_row0", {wa[0], wd[0], 5'(wc[0])}, {3'd0, 56'hAA, 5'd2});
    chk("k1_done_cyc", done_cyc, 3);
    // k=0 config error
    beats.delete();
    run(3'd0, 1'b0, 20);
    repeat (3) tick();
    chk("k0_cfg_err", {8'(err_cyc), 8'(err_n)}, {8'd1, 8'd1});
    chk("k0_no_write_no_busy", {8'(wa.size()), 8'(busy_hi)}, 16'd0);
    // k=2 with bubbles
    beats.delete();
    for (int i = 1; i <= 4; i++) beats.push_back(8'(8'h11 * i));
    run(3'd2, 1'b1, 40);
    chk("k2b_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("k2b_row0", {wa[0], wd[0], 5'(wc[0])}, {3'd0, 56'h2211, 5'd4});
      chk("k2b_row1", {wa[1], wd[1], 5'(wc[1])}, {3'd1, 56'h4433, 5'd8});
    end
    chk("k2b_done_cyc", done_cyc, 9);
    chk("k2b_ready", rdy_bad, 0);
    // reset in the middle of row 1 of a k=3 load
    beats.delete();
    for (int i = 1; i <= 9; i++) beats.push_back(8'(i));
    clear();
    bus.start = 1'b1; bus.kernel_size = 3'd3;
    tick();
    bus.start = 1'b0;
    while (idx < 4 && cyc < 20) begin
      logic acc;
      bus.w_valid = 1'b1; bus.w_data = beats[idx];
      acc = bus.w_ready;
      tick();
      if (acc) idx++;
    end
    bus.w_valid = 1'b0;
    chk("rst_pre_cyc", cyc, 6);
    chk("rst_pre_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.w_ready, bus.wr_RAM_weight, bus.addr_RAM_weight_wr, bus.din_RAM_weight,
        bus.load_done, bus.busy, bus.cfg_err}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("rst_one_write", wa.size(), 1);
    if (wa.size() == 1) chk("rst_row0", {wa[0], wd[0]}, {3'd0, 56'h030201});
    beats.delete();
    for (int i = 1; i <= 4; i++) beats.push_back(8'(8'h11 * i));
    run(3'd2, 1'b0, 30);
    chk("reload_nwr", wa.size(), 2);
    if (wa.size() == 2) begin
      chk("reload_row0", {wa[0], wd[0], 5'(wc[0])}, {3'd0, 56'h2211, 5'd3});
      chk("reload_row1", {wa[1], wd[1], 5'(wc[1])}, {3'd1, 56'h4433, 5'd6});
    end
    chk("reload_done_cyc", done_cyc, 7);
    // k=7 full width with an ignored start mid-load
    beats.delete();
    for (int i = 1; i <= 49; i++) beats.push_back(8'(i));
    ign_cyc = 5;
    run(3'd7, 1'b0, 80);
    ign_cyc = -1;
    chk("k7_nwr", wa.size(), 7);
    for (int r = 0; r < wa.size() && r < 7; r++) begin
      for (int j = 0; j < 7; j++) exp_w[j*8 +: 8] = 8'(7 * r + j + 1);
      chk($sformatf("k7_row%0d", r), {wa[r], wd[r], 5'(0)}, {3'(r), exp_w, 5'(0)});
      chk($sformatf("k7_cyc%0d", r), wc[r], 8 + 8 * r);
    end
    chk("k7_done_cyc", done_cyc, 57);
    chk("k7_ready", rdy_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
